// File: rtl/lut_mux_pkg.sv
// Shared types for the serially configured LUT.
// Holds the configuration FSM states and state helpers.
package lut_mux_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY       = 2'd0,
        ST_LOAD_FIRST  = 2'd1,
        ST_ACTIVE      = 2'd2,
        ST_LOAD_UPDATE = 2'd3
    } state_e;

    function automatic logic is_load(state_e s);
        return (s == ST_LOAD_FIRST) || (s == ST_LOAD_UPDATE);
    endfunction

    function automatic logic has_table(state_e s);
        return (s == ST_ACTIVE) || (s == ST_LOAD_UPDATE);
    endfunction

endpackage

// File: rtl/lut_mux_cfg_mux.sv
// 2:1 multiplexer cell.
// Building block of the truth-table lookup tree.
module mux (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/lut_mux_cfg.sv
// Configurable N_IN-input LUT with serial truth-table load.
// Shadow table is loaded bit by bit, then swapped into the active table.
module lut_mux_cfg #(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_done,
    output logic            configured,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_data,
    output logic            out_valid,
    output logic            out_data
);

    import lut_mux_pkg::*;

    localparam int TT_W = 2 ** N_IN;
    localparam int CW   = $clog2(TT_W + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TT_W-1:0]   shadow_q, shadow_d;
    logic [TT_W-1:0]   active_q, active_d;
    logic              cfg_done_q, cfg_done_d;
    logic              out_valid_q, out_valid_d;
    logic              out_data_q, out_data_d;
    logic              accept;
    logic              last;
    logic              lut_y;

    // State and all registers; reset discards any partial load
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            cnt_q       <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
            cfg_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            cfg_done_q  <= cfg_done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next state, bit capture and table swap; a restart beats a data bit
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        cfg_done_d = 1'b0;
        accept     = is_load(state_q) && cfg_valid && !cfg_start;
        last       = accept && (cnt_q == CW'(TT_W - 1));
        case (state_q)
            ST_EMPTY: begin
                if (cfg_start) begin
                    state_d = ST_LOAD_FIRST;
                    cnt_d   = '0;
                end
            end
            ST_ACTIVE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD_UPDATE;
                    cnt_d   = '0;
                end
            end
            ST_LOAD_FIRST, ST_LOAD_UPDATE: begin
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (accept) begin
                    shadow_d[cnt_q[N_IN-1:0]] = cfg_bit;
                    if (last) begin
                        active_d   = shadow_d;
                        cfg_done_d = 1'b1;
                        state_d    = ST_ACTIVE;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Outputs: registered lookup, data held while no valid result
    always_comb begin
        configured  = has_table(state_q);
        out_valid_d = in_valid && configured;
        out_data_d  = out_valid_d ? lut_y : out_data_q;
    end

    // Lookup tree: level j halves the candidates using in_data[j]
    for (genvar j = 0; j < N_IN; j++) begin : g_lvl
        localparam int W = TT_W >> (j + 1);
        logic [2*W-1:0] d;
        logic [W-1:0]   y;
        if (j == 0) begin : g_leaf
            assign d = active_q;
        end else begin : g_inner
            assign d = g_lvl[j-1].y;
        end
        for (genvar i = 0; i < W; i++) begin : g_mux
            mux u_mux (
                .d0  (d[2*i]),
                .d1  (d[2*i+1]),
                .sel (in_data[j]),
                .y   (y[i])
            );
        end
    end

    assign lut_y     = g_lvl[N_IN-1].y[0];
    assign cfg_done  = cfg_done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_lut_mux_cfg.sv
// Directed bench for lut_mux_cfg.
// Uses a 3-input instance and a 1-input instance.
module tb_lut_mux_cfg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       c3_start = 0, c3_valid = 0, c3_bit = 0;
    logic       i3_valid = 0;
    logic [2:0] i3_data  = '0;
    logic       done3, cfg3, ov3, od3;

    logic       c1_start = 0, c1_valid = 0, c1_bit = 0;
    logic       i1_valid = 0;
    logic [0:0] i1_data  = '0;
    logic       done1, cfg1, ov1, od1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lut_mux_cfg #(.N_IN(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (c3_start),
        .cfg_valid  (c3_valid),
        .cfg_bit    (c3_bit),
        .cfg_done   (done3),
        .configured (cfg3),
        .in_valid   (i3_valid),
        .in_data    (i3_data),
        .out_valid  (ov3),
        .out_data   (od3)
    );

    lut_mux_cfg #(.N_IN(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (c1_start),
        .cfg_valid  (c1_valid),
        .cfg_bit    (c1_bit),
        .cfg_done   (done1),
        .configured (cfg1),
        .in_valid   (i1_valid),
        .in_data    (i1_data),
        .out_valid  (ov1),
        .out_data   (od1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; i3_valid = 1; i1_valid = 1;
        step(); step();
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL reset_ov3 got %b exp 0", ov3); end
        checks++; if (cfg3 !== 1'b0) begin errors++; $display("FAIL reset_cfg3 got %b exp 0", cfg3); end
        checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL reset_done3 got %b exp 0", done3); end
        checks++; if (od3 !== 1'b0) begin errors++; $display("FAIL reset_od3 got %b exp 0", od3); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_ov1 got %b exp 0", ov1); end
        checks++; if (cfg1 !== 1'b0) begin errors++; $display("FAIL reset_cfg1 got %b exp 0", cfg1); end
        rst = 0;
        step();
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL empty_ov3 got %b exp 0", ov3); end
        i3_valid = 0; i1_valid = 0;
        step();
    endtask

    task automatic test_xor3();
        logic [7:0] tbl;
        int pulses;
        tbl = 8'b10010110;
        pulses = 0;
        c3_start = 1;
        step();
        c3_start = 0;
        checks++; if (cfg3 !== 1'b0) begin errors++; $display("FAIL xor_load_first_cfg got %b exp 0", cfg3); end
        for (int k = 0; k < 8; k++) begin
            c3_valid = 1; c3_bit = tbl[k];
            step();
            if (done3 === 1'b1) pulses++;
        end
        c3_valid = 0;
        checks++; if (done3 !== 1'b1) begin errors++; $display("FAIL xor_done got %b exp 1", done3); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL xor_done_pulses got %0d exp 1", pulses); end
        i3_valid = 1;
        for (int i = 0; i < 8; i++) begin
            i3_data = 3'(i);
            step();
            checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL xor_done_clear[%0d] got %b exp 0", i, done3); end
            checks++; if (ov3 !== 1'b1) begin errors++; $display("FAIL xor_ov[%0d] got %b exp 1", i, ov3); end
            checks++; if (od3 !== tbl[i]) begin errors++; $display("FAIL xor_od[%0d] got %b exp %b", i, od3, tbl[i]); end
        end
        i3_valid = 0; i3_data = 0;
        step();
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL hold_ov got %b exp 0", ov3); end
        checks++; if (od3 !== 1'b1) begin errors++; $display("FAIL hold_od got %b exp 1", od3); end
    endtask

    task automatic test_inverter();
        c1_start = 1;
        step();
        c1_start = 0; c1_valid = 1; c1_bit = 1;
        step();
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL inv_done_early got %b exp 0", done1); end
        c1_bit = 0;
        step();
        checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL inv_done got %b exp 1", done1); end
        c1_valid = 0; i1_valid = 1; i1_data = 1'b0;
        step();
        checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL inv_ov got %b exp 1", ov1); end
        checks++; if (od1 !== 1'b1) begin errors++; $display("FAIL inv_in0 got %b exp 1", od1); end
        i1_data = 1'b1;
        step();
        checks++; if (od1 !== 1'b0) begin errors++; $display("FAIL inv_in1 got %b exp 0", od1); end
        i1_valid = 0;
    endtask

    task automatic test_hot_reload();
        logic [7:0] and3;
        logic [7:0] xor3;
        and3 = 8'h80;
        xor3 = 8'b10010110;
        i3_valid = 1; i3_data = 3;
        c3_start = 1;
        step();
        c3_start = 0;
        for (int k = 0; k < 8; k++) begin
            c3_valid = 1; c3_bit = and3[k];
            step();
            checks++; if (cfg3 !== 1'b1) begin errors++; $display("FAIL hot_cfg[%0d] got %b exp 1", k, cfg3); end
            checks++; if (ov3 !== 1'b1 || od3 !== 1'b0) begin errors++; $display("FAIL hot_out3[%0d] got %b/%b exp 1/0", k, ov3, od3); end
            checks++; if (done3 !== (k == 7)) begin errors++; $display("FAIL hot_done[%0d] got %b exp %b", k, done3, (k == 7)); end
        end
        c3_valid = 0;
        step();
        checks++; if (od3 !== 1'b0) begin errors++; $display("FAIL hot_and_in3 got %b exp 0", od3); end
        i3_data = 7;
        step();
        checks++; if (od3 !== 1'b1) begin errors++; $display("FAIL hot_and_in7 got %b exp 1", od3); end
        i3_data = 1;
        step();
        checks++; if (od3 !== 1'b0) begin errors++; $display("FAIL hot_and_in1 got %b exp 0", od3); end
        c3_start = 1;
        step();
        c3_start = 0;
        for (int k = 0; k < 8; k++) begin
            c3_valid = 1; c3_bit = xor3[k];
            step();
            checks++; if (od3 !== 1'b0) begin errors++; $display("FAIL swap_old[%0d] got %b exp 0", k, od3); end
        end
        c3_valid = 0;
        step();
        checks++; if (od3 !== 1'b1) begin errors++; $display("FAIL swap_new got %b exp 1", od3); end
        i3_valid = 0;
    endtask

    task automatic test_abort();
        logic [7:0] maj;
        maj = 8'hE8;
        c3_start = 1;
        step();
        c3_start = 0;
        for (int k = 0; k < 5; k++) begin
            c3_valid = 1; c3_bit = 1;
            step();
        end
        c3_start = 1; c3_valid = 1; c3_bit = 1;
        step();
        checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done3); end
        checks++; if (cfg3 !== 1'b1) begin errors++; $display("FAIL abort_cfg got %b exp 1", cfg3); end
        c3_start = 0;
        for (int k = 0; k < 8; k++) begin
            c3_valid = 1; c3_bit = maj[k];
            step();
            checks++; if (done3 !== (k == 7)) begin errors++; $display("FAIL abort_done[%0d] got %b exp %b", k, done3, (k == 7)); end
        end
        c3_valid = 0; i3_valid = 1;
        for (int i = 0; i < 8; i++) begin
            i3_data = 3'(i);
            step();
            checks++; if (od3 !== maj[i]) begin errors++; $display("FAIL maj_od[%0d] got %b exp %b", i, od3, maj[i]); end
        end
        i3_valid = 0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] xnor3;
        xnor3 = 8'h69;
        c3_start = 1;
        step();
        c3_start = 0;
        for (int k = 0; k < 4; k++) begin
            c3_valid = 1; c3_bit = 1;
            step();
        end
        rst = 1; i3_valid = 1; i3_data = 1;
        step();
        rst = 0; c3_valid = 0;
        checks++; if (cfg3 !== 1'b0) begin errors++; $display("FAIL mid_cfg got %b exp 0", cfg3); end
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL mid_ov got %b exp 0", ov3); end
        checks++; if (od3 !== 1'b0) begin errors++; $display("FAIL mid_od got %b exp 0", od3); end
        step();
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL mid_ov2 got %b exp 0", ov3); end
        for (int k = 0; k < 8; k++) begin
            c3_valid = 1; c3_bit = 1;
            step();
            checks++; if (done3 !== 1'b0 || cfg3 !== 1'b0) begin errors++; $display("FAIL empty_ignore[%0d] got %b/%b exp 0/0", k, done3, cfg3); end
        end
        c3_valid = 0; i3_data = 0;
        c3_start = 1;
        step();
        c3_start = 0;
        for (int k = 0; k < 8; k++) begin
            c3_valid = 1; c3_bit = xnor3[k];
            step();
            checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL first_ov[%0d] got %b exp 0", k, ov3); end
        end
        c3_valid = 0;
        checks++; if (done3 !== 1'b1 || cfg3 !== 1'b1) begin errors++; $display("FAIL first_done got %b/%b exp 1/1", done3, cfg3); end
        step();
        checks++; if (ov3 !== 1'b1 || od3 !== 1'b1) begin errors++; $display("FAIL xnor_in0 got %b/%b exp 1/1", ov3, od3); end
        i3_data = 1;
        step();
        checks++; if (od3 !== 1'b0) begin errors++; $display("FAIL xnor_in1 got %b exp 0", od3); end
        i3_valid = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_xor3();
        test_inverter();
        test_hot_reload();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
